// File: rtl/rco_extender.sv
// rco_extender: extends the 4-bit up/down/load counter to an 8-bit count.
// The high nibble steps once per rising edge of the counter's RCO. The block
// also drives a one-cycle compare-match pulse and a sticky overflow flag.
// Optional feature macro: RCO_EXT_OVF_STOP_EN. When it is defined, a high
// nibble wrap parks the FSM in STOP until CLR or reset.
module rco_extender (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       ENB,
  input  logic [1:0] MODO,
  input  logic [3:0] Q,
  input  logic       RCO,
  input  logic [7:0] CMP,
  input  logic       CLR,
  output logic [7:0] Q8,
  output logic [3:0] QH,
  output logic       MATCH,
  output logic       OVF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t     r_state, w_state_n;
  logic [3:0] r_qh, w_qh_n;
  logic [3:0] r_ql, w_ql_n;
  logic       r_rco_q, w_rco_n;
  logic       r_ovf, w_ovf_n;
  logic       r_match, w_match_n;

  logic       w_event;
  logic       w_wrap;
  logic [7:0] w_next_q8;
  logic       w_hit;

  assign w_event = RCO & ~r_rco_q;

  // Next-state and next-data decode; priority is CLR, then STOP, then ENB.
  always_comb begin
    w_state_n = r_state;
    w_qh_n    = r_qh;
    w_ql_n    = r_ql;
    w_rco_n   = r_rco_q;
    w_ovf_n   = r_ovf;
    w_match_n = 1'b0;
    w_wrap    = 1'b0;
    w_next_q8 = {r_qh, Q};
    w_hit     = 1'b0;
    if (CLR) begin
      w_qh_n    = 4'h0;
      w_ql_n    = 4'h0;
      w_ovf_n   = 1'b0;
      w_state_n = S_IDLE;
    end else if (r_state == S_STOP) begin
      w_state_n = S_STOP;
    end else if (!ENB) begin
      w_state_n = S_IDLE;
    end else begin
      w_ql_n  = Q;
      w_rco_n = RCO;
      case (MODO)
        2'b00: begin
          if (w_event) begin
            w_qh_n = r_qh + 4'd1;
            w_wrap = (r_qh == 4'hF);
          end
        end
        2'b01, 2'b10: begin
          if (w_event) begin
            w_qh_n = r_qh - 4'd1;
            w_wrap = (r_qh == 4'h0);
          end
        end
        default: w_qh_n = 4'h0;
      endcase
      w_ovf_n   = r_ovf | w_wrap;
      w_next_q8 = {w_qh_n, Q};
      w_hit     = (w_next_q8 == CMP);
      case (r_state)
        S_IDLE: w_state_n = S_RUN;
        S_RUN: begin
          if (w_hit) begin
            w_state_n = S_HIT;
            w_match_n = 1'b1;
          end
        end
        S_HIT: begin
          if (!w_hit) w_state_n = S_RUN;
        end
        default: w_state_n = S_IDLE;
      endcase
`ifdef RCO_EXT_OVF_STOP_EN
      if (w_wrap) begin
        w_state_n = S_STOP;
        w_match_n = 1'b0;
      end
`endif
    end
  end

  // State and count registers; asynchronous reset clears everything at once.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= S_IDLE;
      r_qh    <= 4'h0;
      r_ql    <= 4'h0;
      r_rco_q <= 1'b0;
      r_ovf   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_qh    <= w_qh_n;
      r_ql    <= w_ql_n;
      r_rco_q <= w_rco_n;
      r_ovf   <= w_ovf_n;
      r_match <= w_match_n;
    end
  end

  assign Q8    = {r_qh, r_ql};
  assign QH    = r_qh;
  assign MATCH = r_match;
  assign OVF   = r_ovf;

endmodule

// File: tb/tb_rco_extender.sv
// Directed self-checking bench for rco_extender.
module tb_rco_extender;

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic       ENB;
  logic [1:0] MODO;
  logic [3:0] Q;
  logic       RCO;
  logic [7:0] CMP;
  logic       CLR;
  logic [7:0] Q8;
  logic [3:0] QH;
  logic       MATCH;
  logic       OVF;

  int n_tests = 0;
  int n_fail  = 0;

  rco_extender dut (
    .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .Q(Q), .RCO(RCO),
    .CMP(CMP), .CLR(CLR), .Q8(Q8), .QH(QH), .MATCH(MATCH), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_L = 1'b0; ENB = 1'b0; MODO = 2'b00; Q = 4'h0; RCO = 1'b0;
    CMP = 8'hEE; CLR = 1'b0;
    tick(); tick();
    n_tests++;
    if (Q8 !== 8'h00 || QH !== 4'h0 || MATCH !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: Q8=%h QH=%h MATCH=%b OVF=%b want 00 0 0 0", Q8, QH, MATCH, OVF);
    end
    n_tests++;
    if (dut.r_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d want 0", dut.r_state);
    end
    RESET_L = 1'b1;
    // Build Q8 = 0x5A: five RCO pulses, low nibble A.
    ENB = 1'b1; MODO = 2'b00; Q = 4'hA;
    for (int i = 0; i < 5; i++) begin
      RCO = 1'b1; tick();
      RCO = 1'b0; tick();
    end
    n_tests++;
    if (Q8 !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_setup: Q8=%h want 5a", Q8);
    end
    // Assert reset between edges; outputs must clear with no clock.
    #2 RESET_L = 1'b0;
    #1;
    n_tests++;
    if (Q8 !== 8'h00 || MATCH !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: Q8=%h MATCH=%b OVF=%b want 00 0 0", Q8, MATCH, OVF);
    end
    #1 RESET_L = 1'b1;
  endtask

  task automatic test_up_cascade();
    logic [3:0] eqh;
    logic [7:0] exp_q8;
    ENB = 1'b1; MODO = 2'b00; CLR = 1'b0; CMP = 8'hEE;
    for (int w = 0; w < 3; w++) begin
      for (int v = 0; v < 16; v++) begin
        Q = 4'(v); RCO = (v == 15);
        tick();
        eqh = 4'(w + ((v == 15) ? 1 : 0));
        exp_q8 = {eqh, 4'(v)};
        n_tests++;
        if (Q8 !== exp_q8) begin
          n_fail++;
          $display("FAIL up_step w=%0d v=%0d: Q8=%h want %h", w, v, Q8, exp_q8);
        end
      end
    end
    Q = 4'h0; RCO = 1'b0;
    tick();
    n_tests++;
    if (Q8 !== 8'h30 || QH !== 4'h3 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL up_final: Q8=%h QH=%h OVF=%b want 30 3 0", Q8, QH, OVF);
    end
  endtask

  task automatic test_compare();
    int tail[6] = '{0, 1, 2, 2, 3, 4};
    logic [7:0] exp_q8, prev_q8;
    logic       exp_m;
    int         nmatch;
    CLR = 1'b1; tick(); CLR = 1'b0;
    CMP = 8'h12; ENB = 1'b1;
    for (int p = 0; p < 2; p++) begin
      // Load zero to start each pass at 0x00.
      MODO = 2'b11; Q = 4'h0; RCO = 1'b0;
      tick();
      n_tests++;
      if (Q8 !== 8'h00 || MATCH !== 1'b0) begin
        n_fail++;
        $display("FAIL cmp_load p=%0d: Q8=%h MATCH=%b want 00 0", p, Q8, MATCH);
      end
      MODO = 2'b00;
      prev_q8 = 8'h00;
      nmatch = 0;
      for (int k = 1; k < 22; k++) begin
        if (k < 16) begin
          Q = 4'(k); RCO = (k == 15);
          exp_q8 = {((k == 15) ? 4'h1 : 4'h0), 4'(k)};
        end else begin
          Q = 4'(tail[k-16]); RCO = 1'b0;
          exp_q8 = {4'h1, 4'(tail[k-16])};
        end
        tick();
        exp_m = (exp_q8 == 8'h12) && (prev_q8 != 8'h12);
        if (MATCH === 1'b1) nmatch++;
        n_tests++;
        if (Q8 !== exp_q8 || MATCH !== exp_m) begin
          n_fail++;
          $display("FAIL cmp_step p=%0d k=%0d: Q8=%h MATCH=%b want %h %b", p, k, Q8, MATCH, exp_q8, exp_m);
        end
        prev_q8 = exp_q8;
      end
      n_tests++;
      if (nmatch != 1) begin
        n_fail++;
        $display("FAIL cmp_count p=%0d: pulses=%0d want 1", p, nmatch);
      end
    end
    CMP = 8'hEE;
  endtask

  task automatic test_rco_held();
    CLR = 1'b1; tick(); CLR = 1'b0;
    ENB = 1'b1; MODO = 2'b00; Q = 4'h5; RCO = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (QH !== 4'h1) begin
        n_fail++;
        $display("FAIL rco_held c=%0d: QH=%h want 1", i, QH);
      end
    end
    RCO = 1'b0; tick();
    RCO = 1'b1; tick();
    n_tests++;
    if (Q8 !== 8'h25) begin
      n_fail++;
      $display("FAIL rco_rearm: Q8=%h want 25", Q8);
    end
    // Load together with an RCO event: load wins.
    RCO = 1'b0; tick();
    MODO = 2'b11; Q = 4'h4; RCO = 1'b1; tick();
    n_tests++;
    if (Q8 !== 8'h04 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL load_vs_event: Q8=%h OVF=%b want 04 0", Q8, OVF);
    end
    RCO = 1'b0; tick();
  endtask

  task automatic test_down_borrow();
    CLR = 1'b1; tick(); CLR = 1'b0;
    ENB = 1'b1; CMP = 8'hEE; MODO = 2'b11; Q = 4'h0; RCO = 1'b0;
    tick();
    MODO = 2'b01; Q = 4'hF; RCO = 1'b1;
    tick();
    n_tests++;
    if (Q8 !== 8'hFF || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL down_borrow: Q8=%h OVF=%b want ff 1", Q8, OVF);
    end
    Q = 4'hE; RCO = 1'b0;
    tick();
`ifdef RCO_EXT_OVF_STOP_EN
    tick();
    n_tests++;
    if (Q8 !== 8'hFF || MATCH !== 1'b0 || dut.r_state !== 2'd3) begin
      n_fail++;
      $display("FAIL down_stop: Q8=%h MATCH=%b state=%0d want ff 0 3", Q8, MATCH, dut.r_state);
    end
`else
    n_tests++;
    if (Q8 !== 8'hFE || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL down_continue: Q8=%h OVF=%b want fe 1", Q8, OVF);
    end
    MODO = 2'b11; Q = 4'h2;
    tick();
    n_tests++;
    if (Q8 !== 8'h02 || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky_load: Q8=%h OVF=%b want 02 1", Q8, OVF);
    end
`endif
  endtask

  task automatic test_priority();
    // CLR with ENB=1 and a fresh RCO event: CLR wins.
    ENB = 1'b1; MODO = 2'b00; Q = 4'hF; RCO = 1'b1; CLR = 1'b1;
    tick();
    n_tests++;
    if (Q8 !== 8'h00 || OVF !== 1'b0 || MATCH !== 1'b0 || dut.r_state !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_clr: Q8=%h OVF=%b MATCH=%b state=%0d want 00 0 0 0", Q8, OVF, MATCH, dut.r_state);
    end
    CLR = 1'b0; RCO = 1'b0; Q = 4'h3;
    tick();
    n_tests++;
    if (Q8 !== 8'h03 || dut.r_state !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_run: Q8=%h state=%0d want 03 1", Q8, dut.r_state);
    end
    // ENB=0 freezes the count and returns to IDLE.
    ENB = 1'b0; Q = 4'h7; RCO = 1'b1;
    tick();
    n_tests++;
    if (Q8 !== 8'h03 || dut.r_state !== 2'd0) begin
      n_fail++;
      $display("FAIL enb_hold: Q8=%h state=%0d want 03 0", Q8, dut.r_state);
    end
  endtask

  initial begin
    test_reset();
    test_up_cascade();
    test_compare();
    test_rco_held();
    test_down_borrow();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
